// File: rtl/pixel_pkg.sv
// pixel_pkg: shared pixel and word geometry for the pixel processing core
package pixel_pkg;
   localparam int PIX_W = 8;
   localparam int WORD_W = 32;
   localparam int PIX_PER_WORD = 4;
   localparam int LANE_W = $clog2(PIX_PER_WORD);
endpackage

// File: rtl/pixel_packer_if.sv
// pixel_packer_if: pixel stream into the packer and packed word stream out of it
interface pixel_packer_if;
   import pixel_pkg::*;
   logic [PIX_W-1:0] pixel_in;
   logic valid_in;
   logic ready_out;
   logic [WORD_W-1:0] word_out;
   logic word_last;
   logic word_valid;
   logic word_ready;
   modport slave (
      input pixel_in, valid_in, word_ready,
      output ready_out, word_out, word_last, word_valid
   );
   modport master (
      output pixel_in, valid_in, word_ready,
      input ready_out, word_out, word_last, word_valid
   );
endinterface

// File: rtl/pixel_word_fifo.sv
// pixel_word_fifo: synchronous first-word-fall-through FIFO, head reads zero when empty
module pixel_word_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic push,
   input  logic pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic full,
   output logic empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] cnt;
   logic do_push, do_pop;
   assign full = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = empty ? '0 : mem[rd_ptr];
   assign level = cnt;
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   // clear outranks a same-cycle pop so a soft clear always leaves the FIFO empty
   always_ff @(posedge clk)
      if (!rstn || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/pixel_packer.sv
// pixel_packer: packs four 8-bit pixels into little-endian 32-bit words with frame framing
module pixel_packer
   import pixel_pkg::*;
#(
   parameter int FRAME_PIXELS = 1024,
   parameter int FIFO_DEPTH = 8
) (
   input  logic clk,
   input  logic rstn,
   input  logic soft_clr,
   pixel_packer_if.slave bus,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [15:0] frame_count,
   output logic frame_done
);
   localparam logic [19:0] LAST_IDX = 20'(FRAME_PIXELS - 1);
   localparam logic [LANE_W-1:0] TOP_LANE = LANE_W'(PIX_PER_WORD - 1);
   logic [LANE_W-1:0] byte_idx;
   logic [19:0] pix_idx;
   logic [WORD_W-PIX_W-1:0] pack;
   logic [WORD_W-1:0] word;
   logic [WORD_W:0] head;
   logic full, empty, ready, accept, pix_last, push;
   assign ready = !full && rstn && !soft_clr;
   assign accept = bus.valid_in && ready;
   assign pix_last = pix_idx == LAST_IDX;
   assign push = accept && (byte_idx == TOP_LANE || pix_last);
   // lanes above byte_idx are already zero in pack, which also zero-pads a short last word
   assign word = {{PIX_W{1'b0}}, pack} | (WORD_W'(bus.pixel_in) << (PIX_W * byte_idx));
   always_ff @(posedge clk)
      if (!rstn || soft_clr) begin
         byte_idx <= '0;
         pix_idx <= '0;
         pack <= '0;
         frame_count <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= push && pix_last;
         if (push && pix_last) frame_count <= frame_count + 16'd1;
         if (accept) begin
            pix_idx <= pix_last ? '0 : pix_idx + 20'd1;
            byte_idx <= push ? '0 : byte_idx + LANE_W'(1);
            pack <= push ? '0 : word[WORD_W-PIX_W-1:0];
         end
      end
   pixel_word_fifo #(.WIDTH(WORD_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rstn(rstn),
      .clear(soft_clr),
      .push(push),
      .pop(bus.word_ready),
      .din({pix_last, word}),
      .dout(head),
      .full(full),
      .empty(empty),
      .level(fifo_level)
   );
   assign bus.ready_out = ready;
   assign bus.word_out = head[WORD_W-1:0];
   assign bus.word_last = head[WORD_W];
   assign bus.word_valid = !empty;
endmodule

// File: doc/pixel_packer.md
# pixel_packer

Downstream stage of the pixel processing core. Accepts the 8-bit processed pixel stream with a valid/ready handshake and packs four pixels into one 32-bit little-endian word. Words are buffered in a small synchronous FIFO and drained by the RISC-V side through a valid/ready word port. Frames are delimited by a pixel counter; a short final word is zero-padded and marked last.

## Interface
- FRAME_PIXELS, 1024: pixels per frame; range 1..2^20.
- FIFO_DEPTH, 8: word FIFO entries; power of two, ≥2.
- clk  in  1  single clock, all logic rising-edge.
- rstn  in  1  synchronous, active-low reset; sampled on clk.
- pixel_in  in  8  pixel from the processing stage.
- valid_in  in  1  pixel_in valid.
- ready_out  out  1  packer can accept a pixel this cycle.
- soft_clr  in  1  synchronous clear of packer, FIFO and counters; same effect as reset.
- word_out  out  32  packed word, FIFO head; first pixel of the word in [7:0].
- word_last  out  1  head word holds the last pixel of a frame.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer takes head word when word_valid.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current word count.
- frame_count  out  16  completed frames, wraps at 65535 -> 0.
- frame_done  out  1  one-cycle pulse per completed frame.

## Operation
- Accept: pixel_in taken on a clk edge when valid_in && ready_out.
- ready_out = !fifo_full && rstn && !soft_clr; combinational from registered state.
- Pack register holds bytes 0..2; byte_idx (2 bits) selects the lane for the next accepted pixel.
- Push condition: accepted pixel with byte_idx==3, or the accepted pixel is last of frame (pix_idx==FRAME_PIXELS-1).
- On push: FIFO gets {last, word}; word = accepted pixel in lane byte_idx, earlier lanes from pack register, higher lanes 0. byte_idx -> 0, pack register cleared.
- No push: pixel stored in lane byte_idx; byte_idx+1.
- pix_idx (20 bits) increments per accepted pixel; wraps to 0 after FRAME_PIXELS-1.
- last = 1 iff the pushed word contains pix_idx FRAME_PIXELS-1; frame_count+1 and frame_done=1 the next cycle.
- Pop: word_valid && word_ready removes head; first-word-fall-through, so word_out/word_last show the new head next cycle.
- Push and pop in the same cycle: level unchanged. When full, no accept even if a pop occurs that cycle; ready_out rises the cycle after the pop.
- Reset or soft_clr: FIFO emptied, byte_idx=0, pix_idx=0, pack register=0, frame_count=0; partial words discarded.

## Timing
- Reset values: ready_out=0 while rstn low, 1 the first cycle after release; word_valid=0, word_last=0, word_out=0 (empty-FIFO head reads 0), fifo_level=0, frame_count=0, frame_done=0.
- Latency: pushing accept at edge N -> word_valid=1 after edge N (visible cycle N+1), when the FIFO was empty.
- Throughput: 1 pixel/cycle sustained while word_ready=1; the FIFO never fills in that case.
- frame_done asserts the cycle after the edge that accepts the last frame pixel, for exactly 1 cycle.
- soft_clr takes priority over accept and pop in the same cycle.

## Structure
- Shared package pixel_pkg: PIX_W=8, WORD_W=32, PIX_PER_WORD=4. Also used by the processing stage and producer.
- Sub-module pixel_word_fifo: synchronous FWFT FIFO with parameters WIDTH=33 and DEPTH. Ports: push, pop, din, dout, full, empty, level. Internal clear input for soft_clr.
- Packer control (byte_idx, pix_idx, frame logic) lives in pixel_packer itself.

## Test plan
- Pixels 0x11,0x22,0x33,0x44 on consecutive cycles, word_ready=1 -> word_out=0x44332211, word_last=0, word_valid for 1 cycle.
- FRAME_PIXELS=6, pixels 0x01..0x06 -> words 0x04030201 (last=0), then 0x00000605 (last=1); frame_done 1 cycle; frame_count=1.
- word_ready=0, FIFO_DEPTH=8, 40 pixels offered -> 32 accepted, fifo_level=8, ready_out=0. One pop -> ready_out=1 next cycle; no pixel lost or duplicated.
- Full FIFO with simultaneous pop and valid_in -> pixel not accepted that cycle, level 7, accepted next cycle.
- Reset mid-word after 2 pixels, then 0xAA,0xBB,0xCC,0xDD -> word 0xDDCCBBAA; no stale bytes; frame_count=0.
- FRAME_PIXELS=1024, 3 back-to-back frames with random word_ready backpressure -> 768 words, word_last on words 256/512/768, frame_count=3, data matches reference model.
